// File: rtl/spw_monitor_pack.sv
// Status packer for the SpaceWire monitor PIO: registers link state, sticky
// error flags and a wrapping time-code tick counter into one 14-bit word.
module spw_monitor_pack #(
  parameter int         TICK_W   = 6,
  parameter logic [2:0] RUN_CODE = 3'd5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          link_state,
  input  logic                err_disc,
  input  logic                err_par,
  input  logic                err_esc,
  input  logic                err_credit,
  input  logic                tick_out,
  input  logic                clr_errors,
  input  logic                clr_ticks,
  output logic [8+TICK_W-1:0] monitor_out
);

  logic [2:0]        link_q;
  logic              running_q;
  logic [3:0]        err_q;
  logic [TICK_W-1:0] tick_cnt_q;

  logic [3:0]        err_in;
  logic [3:0]        err_next;
  logic [TICK_W-1:0] tick_cnt_next;

  assign err_in = {err_credit, err_esc, err_par, err_disc};

  always_comb begin
    // A set pulse beats a simultaneous clear so no error event is lost.
    err_next = err_in | (err_q & {4{~clr_errors}});

    tick_cnt_next = tick_cnt_q;
    if (clr_ticks) begin
      tick_cnt_next = tick_out ? TICK_W'(1) : '0;
    end else if (tick_out) begin
      tick_cnt_next = tick_cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the packed word updates atomically on one edge.
    if (reset) begin
      link_q     <= '0;
      running_q  <= 1'b0;
      err_q      <= '0;
      tick_cnt_q <= '0;
    end else begin
      link_q     <= link_state;
      running_q  <= (link_state == RUN_CODE);
      err_q      <= err_next;
      tick_cnt_q <= tick_cnt_next;
    end
  end

  // Pure concatenation of registers: no input reaches the output combinationally.
  assign monitor_out = {tick_cnt_q, err_q, running_q, link_q};

endmodule

// File: tb/tb_spw_monitor_pack.sv
// Self-checking bench for spw_monitor_pack: directed steps plus a randomized
// phase, all compared against a behavioural model of the monitor word.
module tb_spw_monitor_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  link_state;
  logic        err_disc, err_par, err_esc, err_credit;
  logic        tick_out, clr_errors, clr_ticks;
  logic [13:0] monitor_out;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int unsigned m_link;
  bit          m_err [4];
  int unsigned m_cnt;

  spw_monitor_pack dut (
    .clk         (clk),
    .reset       (reset),
    .link_state  (link_state),
    .err_disc    (err_disc),
    .err_par     (err_par),
    .err_esc     (err_esc),
    .err_credit  (err_credit),
    .tick_out    (tick_out),
    .clr_errors  (clr_errors),
    .clr_ticks   (clr_ticks),
    .monitor_out (monitor_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] model_word();
    logic [13:0] w;
    w[2:0]  = 3'(m_link);
    w[3]    = (m_link == 5);
    w[4]    = m_err[0];
    w[5]    = m_err[1];
    w[6]    = m_err[2];
    w[7]    = m_err[3];
    w[13:8] = 6'(m_cnt);
    return w;
  endfunction

  task automatic idle_inputs();
    err_disc = 0; err_par = 0; err_esc = 0; err_credit = 0;
    tick_out = 0; clr_errors = 0; clr_ticks = 0;
  endtask

  // One clock: update the model from the inputs held across the edge, then
  // compare the word #1 after the edge and return to the falling edge.
  task automatic cycle(input string tag);
    bit e [4];
    @(posedge clk);
    e = '{err_disc, err_par, err_esc, err_credit};
    if (reset) begin
      m_link = 0; m_cnt = 0;
      foreach (m_err[i]) m_err[i] = 0;
    end else begin
      m_link = link_state;
      foreach (m_err[i])
        if (e[i]) m_err[i] = 1;
        else if (clr_errors) m_err[i] = 0;
      if (clr_ticks) m_cnt = tick_out ? 1 : 0;
      else if (tick_out) m_cnt = (m_cnt + 1) % 64;
    end
    #1;
    check(tag, monitor_out, model_word());
    @(negedge clk);
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  logic [3:0] walk_exp [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hD};

  initial begin
    m_link = 0; m_cnt = 0;
    foreach (m_err[i]) m_err[i] = 0;
    idle_inputs();
    link_state = 3'd5;
    err_par = 1; tick_out = 1; reset = 1;
    @(negedge clk);

    // Reset dominates simultaneous pulses
    cycle("reset_c1"); check("reset_zero1", monitor_out, 14'h0000);
    cycle("reset_c2"); check("reset_zero2", monitor_out, 14'h0000);
    reset = 0; idle_inputs(); link_state = 0;
    cycle("post_reset"); check("post_reset_zero", monitor_out, 14'h0000);

    // Link state walk
    for (int s = 0; s < 6; s++) begin
      link_state = 3'(s);
      cycle("walk");
      check($sformatf("walk_%0d", s), {10'd0, monitor_out[3:0]}, {10'd0, walk_exp[s]});
    end
    link_state = 3'd7;
    cycle("walk7"); check("illegal_7", {10'd0, monitor_out[3:0]}, 14'h0007);
    link_state = 3'd6;
    cycle("walk6"); check("illegal_6", {10'd0, monitor_out[3:0]}, 14'h0006);
    link_state = 3'd5;

    // Sticky disconnect error
    err_disc = 1; cycle("disc_set"); err_disc = 0;
    check("disc_set_bit", {13'd0, monitor_out[4]}, 14'd1);
    cycles("disc_hold", 100);
    check("disc_hold_bit", {13'd0, monitor_out[4]}, 14'd1);
    clr_errors = 1; cycle("disc_clr"); clr_errors = 0;
    check("disc_clr_bit", {13'd0, monitor_out[4]}, 14'd0);
    err_credit = 1; clr_errors = 1; cycle("credit_vs_clr"); idle_inputs();
    check("credit_wins", {13'd0, monitor_out[7]}, 14'd1);
    err_esc = 1; cycle("esc_set"); idle_inputs();
    check("esc_bit", {13'd0, monitor_out[6]}, 14'd1);

    // Tick wrap
    clr_ticks = 1; cycle("tick_clr0"); clr_ticks = 0;
    tick_out = 1; cycles("tick_fill", 63); tick_out = 0;
    cycle("tick_hold");
    check("tick_63", {8'd0, monitor_out[13:8]}, 14'd63);
    tick_out = 1; cycle("tick_wrap"); tick_out = 0;
    check("tick_wrap0", {8'd0, monitor_out[13:8]}, 14'd0);
    tick_out = 1; cycles("tick_burst", 10); tick_out = 0;
    check("tick_burst10", {8'd0, monitor_out[13:8]}, 14'd10);

    // Simultaneous clears, flags untouched
    clr_ticks = 1; cycle("sc_clr"); clr_ticks = 0;
    tick_out = 1; cycles("sc_fill", 20); tick_out = 0;
    check("sc_20", {8'd0, monitor_out[13:8]}, 14'd20);
    clr_ticks = 1; tick_out = 1; cycle("sc_both"); idle_inputs();
    check("sc_both_1", {8'd0, monitor_out[13:8]}, 14'd1);
    check("sc_flags_kept", {10'd0, monitor_out[7:4]}, 14'h000C);
    clr_ticks = 1; cycle("sc_only"); idle_inputs();
    check("sc_only_0", {8'd0, monitor_out[13:8]}, 14'd0);
    check("sc_flags_kept2", {10'd0, monitor_out[7:4]}, 14'h000C);

    // Link drop keeps flags and counter
    clr_errors = 1; clr_ticks = 1; cycle("ld_clear"); idle_inputs();
    link_state = 3'd5; err_par = 1; cycle("ld_par"); err_par = 0;
    tick_out = 1; cycles("ld_ticks", 7); tick_out = 0;
    link_state = 3'd0; cycle("ld_drop");
    check("link_drop", monitor_out, 14'h0720);

    // Mid-operation reset with pulses on the same cycle
    reset = 1; err_disc = 1; err_esc = 1; tick_out = 1; link_state = 3'd5;
    cycle("mid_reset"); check("mid_reset_zero", monitor_out, 14'h0000);
    reset = 0;
    cycle("first_after_reset");
    check("first_pulse_taken", monitor_out, 14'h015D);
    idle_inputs();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(99) == 0);
      link_state = 3'($urandom);
      err_disc   = ($urandom_range(15) == 0);
      err_par    = ($urandom_range(15) == 0);
      err_esc    = ($urandom_range(15) == 0);
      err_credit = ($urandom_range(15) == 0);
      tick_out   = ($urandom_range(1) == 0);
      clr_errors = ($urandom_range(19) == 0);
      clr_ticks  = ($urandom_range(49) == 0);
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
